// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- constants shared by the ALU and its issue stage.
//   alu_op_e        : 4-bit ALU operation encoding
//   OPC_*           : RV32I major opcodes decoded by alu_issue
//   imm_i/u/b()     : RV32I immediate extraction helpers
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- purely combinational 32-bit integer ALU.
//   operand_a, operand_b : 32-bit operands
//   opcode               : 4-bit operation (alu_op_e)
//   result               : 32-bit result, wraps modulo 2^32
//   z                    : high when result is zero
// Shift amounts use operand_b[4:0].
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [3:0]  opcode,
    output logic [31:0] result,
    output logic        z
);

    always_comb begin
        result = '0;
        case (opcode)
            ALU_ADD:  result = operand_a + operand_b;
            ALU_SUB:  result = operand_a - operand_b;
            ALU_SLL:  result = operand_a << operand_b[4:0];
            ALU_SLT:  result = {31'b0, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: result = {31'b0, operand_a < operand_b};
            ALU_XOR:  result = operand_a ^ operand_b;
            ALU_OR:   result = operand_a | operand_b;
            ALU_AND:  result = operand_a & operand_b;
            ALU_SRL:  result = operand_a >> operand_b[4:0];
            ALU_SRA:  result = $unsigned($signed(operand_a) >>> operand_b[4:0]);
            default:  result = '0;
        endcase
    end

    assign z = (result == 32'd0);

endmodule

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue -- RV32I integer decode/issue stage in front of the alu.
// Two register stages: S1 holds the decoded operation and operands, the alu
// evaluates combinationally off S1, and S2 holds the writeback beat.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             instruction handshake
//   in_instr, in_pc               instruction word and its PC
//   in_rs1_data, in_rs2_data      source register values
//   out_valid/out_ready           writeback handshake
//   out_rd, out_wdata, out_we     destination, result, write enable
//   out_illegal                   illegal-instruction beat flag
//   out_br_taken, out_br_target   branch outcome (ALU_ISSUE_BRANCH_EN only)
//
// Parameter ILLEGAL_TRAP: 1 = illegal instructions emit a flagged beat,
//                         0 = they are accepted and silently dropped.
// Macro ALU_ISSUE_BRANCH_EN: decode BRANCH; otherwise BRANCH is illegal.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. While out_valid is high and out_ready low every out_* signal
// holds; in_ready may depend combinationally on out_ready.
// ---------------------------------------------------------------------------
module alu_issue
    import alu_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_wdata,
    output logic        out_we,
`ifdef ALU_ISSUE_BRANCH_EN
    output logic        out_br_taken,
    output logic [31:0] out_br_target,
`endif
    output logic        out_illegal
);

    localparam bit TRAP_EN = (ILLEGAL_TRAP != 0);

    // ---------------- decode ----------------
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [3:0]  w_dec_op;
    logic [31:0] w_dec_a;
    logic [31:0] w_dec_b;
    logic        w_dec_illegal;
    logic        w_dec_branch;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    always_comb begin
        w_dec_op      = ALU_ADD;
        w_dec_a       = in_rs1_data;
        w_dec_b       = in_rs2_data;
        w_dec_illegal = 1'b0;
        w_dec_branch  = 1'b0;
        case (w_opc)
            OPC_OP: begin
                case (w_f3)
                    3'b000:  w_dec_op = w_f7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  w_dec_op = ALU_SLL;
                    3'b010:  w_dec_op = ALU_SLT;
                    3'b011:  w_dec_op = ALU_SLTU;
                    3'b100:  w_dec_op = ALU_XOR;
                    3'b101:  w_dec_op = w_f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  w_dec_op = ALU_OR;
                    default: w_dec_op = ALU_AND;
                endcase
                // 0100000 is only meaningful as sub / sra
                if (w_f7 == 7'b0100000)
                    w_dec_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
                else if (w_f7 != 7'b0000000)
                    w_dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                w_dec_b = imm_i(in_instr);
                case (w_f3)
                    3'b000:  w_dec_op = ALU_ADD;
                    3'b001: begin
                        w_dec_op      = ALU_SLL;
                        w_dec_illegal = (w_f7 != 7'b0000000);
                    end
                    3'b010:  w_dec_op = ALU_SLT;
                    3'b011:  w_dec_op = ALU_SLTU;
                    3'b100:  w_dec_op = ALU_XOR;
                    3'b101: begin
                        w_dec_op      = w_f7[5] ? ALU_SRA : ALU_SRL;
                        w_dec_illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                    end
                    3'b110:  w_dec_op = ALU_OR;
                    default: w_dec_op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                w_dec_a = 32'd0;
                w_dec_b = imm_u(in_instr);
            end
            OPC_AUIPC: begin
                w_dec_a = in_pc;
                w_dec_b = imm_u(in_instr);
            end
`ifdef ALU_ISSUE_BRANCH_EN
            OPC_BRANCH: begin
                w_dec_branch = 1'b1;
                // funct3[2]=0: equality via sub/z; otherwise slt or sltu
                if (!w_f3[2])
                    w_dec_op = ALU_SUB;
                else
                    w_dec_op = w_f3[1] ? ALU_SLTU : ALU_SLT;
                w_dec_illegal = (w_f3[2:1] == 2'b01);
            end
`endif
            default: w_dec_illegal = 1'b1;
        endcase
    end

    // ---------------- pipeline control ----------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_load;
    logic w_in_ready;

    assign w_s2_load  = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_load;   // S1 advances whenever S2 loads
    assign in_ready   = w_in_ready;
    assign out_valid  = r_s2_valid;

    // ---------------- S1 ----------------
    logic [3:0]  r_s1_op;
    logic [31:0] r_s1_a;
    logic [31:0] r_s1_b;
    logic [4:0]  r_s1_rd;
    logic        r_s1_we;
    logic        r_s1_illegal;
`ifdef ALU_ISSUE_BRANCH_EN
    logic        r_s1_branch;
    logic        r_s1_br_eq;
    logic        r_s1_br_inv;
    logic [31:0] r_s1_pc;
    logic [31:0] r_s1_imm_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_op      <= 4'd0;
            r_s1_a       <= 32'd0;
            r_s1_b       <= 32'd0;
            r_s1_rd      <= 5'd0;
            r_s1_we      <= 1'b0;
            r_s1_illegal <= 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
            r_s1_branch  <= 1'b0;
            r_s1_br_eq   <= 1'b0;
            r_s1_br_inv  <= 1'b0;
            r_s1_pc      <= 32'd0;
            r_s1_imm_b   <= 32'd0;
`endif
        end else if (w_in_ready) begin
            // A dropped illegal instruction completes its handshake but never occupies S1
            r_s1_valid   <= in_valid && (!w_dec_illegal || TRAP_EN);
            r_s1_op      <= w_dec_op;
            r_s1_a       <= w_dec_a;
            r_s1_b       <= w_dec_b;
            // Beats without a register result carry rd=0
            r_s1_rd      <= (w_dec_illegal || w_dec_branch) ? 5'd0 : in_instr[11:7];
            r_s1_we      <= !w_dec_illegal && !w_dec_branch && (in_instr[11:7] != 5'd0);
            r_s1_illegal <= w_dec_illegal;
`ifdef ALU_ISSUE_BRANCH_EN
            r_s1_branch  <= w_dec_branch && !w_dec_illegal;
            r_s1_br_eq   <= !w_f3[2];
            r_s1_br_inv  <= w_f3[0];
            r_s1_pc      <= in_pc;
            r_s1_imm_b   <= imm_b(in_instr);
`endif
        end
    end

    // ---------------- execute ----------------
    logic [31:0] w_alu_result;
    logic        w_alu_z;
    logic        w_no_data;

    alu u_alu (
        .operand_a (r_s1_a),
        .operand_b (r_s1_b),
        .opcode    (r_s1_op),
        .result    (w_alu_result),
        .z         (w_alu_z)
    );

`ifdef ALU_ISSUE_BRANCH_EN
    logic [31:0] w_br_target;
    logic        w_br_taken;
    assign w_br_target = r_s1_pc + r_s1_imm_b;
    assign w_br_taken  = r_s1_branch &&
                         (r_s1_br_inv ^ (r_s1_br_eq ? w_alu_z : w_alu_result[0]));
    assign w_no_data   = r_s1_illegal || r_s1_branch;
`else
    assign w_no_data   = r_s1_illegal;
`endif

    // ---------------- S2 ----------------
    logic [4:0]  r_out_rd;
    logic [31:0] r_out_wdata;
    logic        r_out_we;
    logic        r_out_illegal;
`ifdef ALU_ISSUE_BRANCH_EN
    logic        r_out_br_taken;
    logic [31:0] r_out_br_target;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid      <= 1'b0;
            r_out_rd        <= 5'd0;
            r_out_wdata     <= 32'd0;
            r_out_we        <= 1'b0;
            r_out_illegal   <= 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
            r_out_br_taken  <= 1'b0;
            r_out_br_target <= 32'd0;
`endif
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_rd      <= r_s1_rd;
                r_out_we      <= r_s1_we;
                r_out_illegal <= r_s1_illegal;
                // A zero result (z) takes the same constant path as a beat with no data
                r_out_wdata   <= (w_no_data || w_alu_z) ? 32'd0 : w_alu_result;
`ifdef ALU_ISSUE_BRANCH_EN
                r_out_br_taken  <= w_br_taken;
                r_out_br_target <= r_s1_branch ? w_br_target : 32'd0;
`endif
            end
        end
    end

    assign out_rd      = r_out_rd;
    assign out_wdata   = r_out_wdata;
    assign out_we      = r_out_we;
    assign out_illegal = r_out_illegal;
`ifdef ALU_ISSUE_BRANCH_EN
    assign out_br_taken  = r_out_br_taken;
    assign out_br_target = r_out_br_target;
`endif

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter ILLEGAL_TRAP, default 1, SHALL select illegal-instruction handling: 1 emits a flagged beat, 0 drops the instruction silently.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid/in_ready  in/out  1/1  instruction-side handshake; transfer when both high.
REQ-005 in_instr, in_pc, in_rs1_data, in_rs2_data  in  32 each  RV32I instruction, its PC, operand register values.
REQ-006 out_valid/out_ready  out/in  1/1  writeback-side handshake; transfer when both high.
REQ-007 out_rd 5, out_wdata 32, out_we 1, out_illegal 1  out  destination, result, write enable, illegal flag.
REQ-008 out_br_taken 1, out_br_target 32  out  branch outcome and target; present only under ALU_ISSUE_BRANCH_EN.

Function
REQ-009 Block SHALL be the initiator of the ALU interface: decode instruction, drive operand_a/operand_b/4-bit opcode, consume result and z.
REQ-010 ALU opcode encoding SHALL be add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, or 0110, and 0111, srl 1000, sra 1001.
REQ-011 OP (0110011): funct3/funct7 map to add/sub/sll/slt/sltu/xor/srl/sra/or/and; funct7 other than 0000000, or 0100000 with add/srl, SHALL be illegal.
REQ-012 OP-IMM (0010011): b = sign-extended imm_i; slli/srli require imm[11:5]=0000000, srai requires 0100000, else illegal.
REQ-013 LUI: a=0, b=imm_u, add; AUIPC: a=in_pc, b=imm_u, add.
REQ-014 Any other opcode SHALL be illegal.
REQ-015 Two-stage pipeline: S1 registers decoded opcode, operands, rd, flags; ALU is combinational off S1; S2 registers result.
REQ-016 Latency: beat accepted at edge N SHALL appear on out_* after edge N+2 with out_ready high; throughput one per cycle.
REQ-017 S2 loads when !s2_valid or out_ready; S1 advances when S2 loads; in_ready = !s1_valid or S1 advancing.
REQ-018 Under backpressure, out_* SHALL hold stable while out_valid high and out_ready low; no drop, duplication or reordering.
REQ-019 rd=0 SHALL produce a beat with out_we=0.
REQ-020 Illegal: ILLEGAL_TRAP=1 -> beat with out_illegal=1, out_we=0, out_wdata=0; ILLEGAL_TRAP=0 -> no beat, S1 not loaded.
REQ-021 Arithmetic SHALL wrap modulo 2^32; shift amount is operand_b[4:0].

Reset
REQ-022 rst SHALL clear s1_valid, s2_valid and all out_* registers to 0, in_ready high in the cycle following reset.
REQ-023 rst asserted mid-operation SHALL discard all in-flight beats without emitting them; no beat accepted during rst.

Configuration
REQ-024 With ALU_ISSUE_BRANCH_EN defined, BRANCH (1100011) SHALL decode: beq/bne -> sub, taken on z / !z; blt/bge -> slt, taken on result 1/0; bltu/bgeu -> sltu likewise; out_we=0; out_br_target = in_pc + sign-extended imm_b from a dedicated S1 adder; funct3 010/011 illegal.
REQ-025 Without ALU_ISSUE_BRANCH_EN, BRANCH SHALL be illegal and out_br_taken/out_br_target SHALL not exist.

Structure
REQ-026 ALU opcode constants and RV32I major-opcode constants SHALL live in shared package alu_pkg.
REQ-027 Block SHALL instantiate existing sub-module alu unchanged; decode, pipeline control and branch adder stay in alu_issue.

Verification
REQ-028 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> two cycles later out_rd=3, out_wdata=12, out_we=1.
REQ-029 srai x5,x6,4 (0x40435293), rs1=0x80000000 -> out_wdata=0xF8000000.
REQ-030 Three back-to-back beats, out_ready low 3 cycles -> in_ready low after two accepted; all three emerge in order, unchanged.
REQ-031 0xFFFFFFFF -> ILLEGAL_TRAP=1: out_illegal=1, out_we=0; ILLEGAL_TRAP=0: no out_valid.
REQ-032 beq x1,x2,+8 (0x00208463), rs1=rs2=9, pc=0x100, macro on -> out_br_taken=1, out_br_target=0x108, out_we=0; macro off -> out_illegal=1.
REQ-033 rst pulsed with two beats in flight -> no out_valid afterwards, in_ready=1 next cycle.
